// File: rtl/interp_col_transpose_buffer_pkg.sv
// -----------------------------------------------------------------------------
// interp_col_transpose_buffer_pkg
// Shared constants, FSM encodings and slot helpers for the interpolation
// line/column datapath (transpose buffer, line selector, interpolation stages).
//   SAMPLE_W  : bits per sample
//   N_SAMPLES : samples per line, lines per block
//   LINE_W    : packed line/column width, derived from the two above
//   CNT_W     : width of row/column index counters
// -----------------------------------------------------------------------------
package interp_col_transpose_buffer_pkg;

    localparam int SAMPLE_W  = 9;
    localparam int N_SAMPLES = 11;
    localparam int LINE_W    = N_SAMPLES * SAMPLE_W;
    localparam int CNT_W     = $clog2(N_SAMPLES);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } tb_state_e;

    // Extract sample 'idx' from a packed line (bit offset SAMPLE_W*idx).
    // Out-of-range indices return zero instead of reading past the bus.
    function automatic logic [SAMPLE_W-1:0] get_slot(
        input logic [LINE_W-1:0] line,
        input logic [CNT_W-1:0]  idx
    );
        logic [SAMPLE_W-1:0] slot;
        slot = {SAMPLE_W{1'b0}};
        for (int i = 0; i < N_SAMPLES; i++) begin
            if (idx == CNT_W'(i)) begin
                slot = line[SAMPLE_W*i +: SAMPLE_W];
            end
        end
        return slot;
    endfunction

endpackage

// File: rtl/interp_col_transpose_buffer_array.sv
// -----------------------------------------------------------------------------
// interp_col_transpose_buffer_array
// N_SAMPLES x LINE_W storage for one block. Rows are written whole; reads
// return one column, assembled from sample 'rd_col' of every row, with row r
// placed in slot r of the packed output.
//   clk         : clock
//   wr_en       : write wr_line into row wr_row
//   wr_row      : row index to write
//   wr_line     : packed line to store
//   rd_col      : column index to read (combinational)
//   rd_col_data : packed column, row r in slot r
// -----------------------------------------------------------------------------
module interp_col_transpose_buffer_array
    import interp_col_transpose_buffer_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [CNT_W-1:0]  wr_row,
    input  logic [LINE_W-1:0] wr_line,
    input  logic [CNT_W-1:0]  rd_col,
    output logic [LINE_W-1:0] rd_col_data
);

    // Contents are never cleared: the FSM only exposes rows it has written.
    logic [LINE_W-1:0] mem_r [N_SAMPLES];
    logic [LINE_W-1:0] col_s;

    // Row write port: one decoded enable per row.
    always_ff @(posedge clk) begin
        for (int r = 0; r < N_SAMPLES; r++) begin
            if (wr_en && (wr_row == CNT_W'(r))) begin
                mem_r[r] <= wr_line;
            end
        end
    end

    // Column read port: gather sample rd_col of every row into slot r.
    always_comb begin
        col_s = {LINE_W{1'b0}};
        for (int r = 0; r < N_SAMPLES; r++) begin
            col_s[SAMPLE_W*r +: SAMPLE_W] = get_slot(mem_r[r], rd_col);
        end
    end

    assign rd_col_data = col_s;

endmodule

// File: rtl/interp_col_transpose_buffer.sv
// -----------------------------------------------------------------------------
// interp_col_transpose_buffer
// Collects N_SAMPLES lines into a single-bank array (FILL), then replays it
// column by column (DRAIN) so the vertical pass sees transposed data.
//   CLK        : clock, rising edge
//   RST        : synchronous active-high reset
//   LINE_IN    : input line, sample s at [SAMPLE_W*s +: SAMPLE_W]
//   LINE_VALID : LINE_IN valid
//   LINE_READY : buffer accepts a line (FILL only)
//   COL_OUT    : output column, row r in slot r; zero when COL_VALID is low
//   COL_VALID  : COL_OUT valid (DRAIN only)
//   COL_READY  : consumer accepts the column
//   COL_LAST   : final column of the block
//   BUSY       : array holds accepted data not yet fully drained
// -----------------------------------------------------------------------------
module interp_col_transpose_buffer
    import interp_col_transpose_buffer_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic [LINE_W-1:0] LINE_IN,
    input  logic              LINE_VALID,
    output logic              LINE_READY,
    output logic [LINE_W-1:0] COL_OUT,
    output logic              COL_VALID,
    input  logic              COL_READY,
    output logic              COL_LAST,
    output logic              BUSY
);

    tb_state_e         state_r;
    logic [CNT_W-1:0]  row_cnt_r;
    logic [CNT_W-1:0]  col_cnt_r;
    logic              line_ready_r;
    logic              col_valid_r;
    logic              col_last_r;

    logic              line_acc_s;
    logic              col_acc_s;
    logic [LINE_W-1:0] col_data_s;
    logic [LINE_W-1:0] col_out_s;

    // Handshakes use the registered ready/valid, so they are only ever true
    // in the matching state.
    assign line_acc_s = LINE_VALID & line_ready_r;
    assign col_acc_s  = col_valid_r & COL_READY;

    interp_col_transpose_buffer_array u_array (
        .clk         (CLK),
        .wr_en       (line_acc_s),
        .wr_row      (row_cnt_r),
        .wr_line     (LINE_IN),
        .rd_col      (col_cnt_r),
        .rd_col_data (col_data_s)
    );

    // FSM, counters and registered handshake flags. The flags are loaded
    // with the value they must have in the following cycle, so a reset
    // cycle shows all-low and ready rises one cycle later.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r      <= ST_FILL;
            row_cnt_r    <= {CNT_W{1'b0}};
            col_cnt_r    <= {CNT_W{1'b0}};
            line_ready_r <= 1'b0;
            col_valid_r  <= 1'b0;
            col_last_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_FILL: begin
                    if (line_acc_s && (row_cnt_r == LAST_IDX)) begin
                        // Block complete: first column is presented next cycle.
                        state_r      <= ST_DRAIN;
                        row_cnt_r    <= {CNT_W{1'b0}};
                        col_cnt_r    <= {CNT_W{1'b0}};
                        line_ready_r <= 1'b0;
                        col_valid_r  <= 1'b1;
                        col_last_r   <= 1'b0;
                    end else if (line_acc_s) begin
                        row_cnt_r    <= row_cnt_r + CNT_W'(1);
                        line_ready_r <= 1'b1;
                        col_valid_r  <= 1'b0;
                        col_last_r   <= 1'b0;
                    end else begin
                        line_ready_r <= 1'b1;
                        col_valid_r  <= 1'b0;
                        col_last_r   <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (col_acc_s && col_last_r) begin
                        // Block drained: the next cycle is the single bubble.
                        state_r      <= ST_FILL;
                        col_cnt_r    <= {CNT_W{1'b0}};
                        line_ready_r <= 1'b1;
                        col_valid_r  <= 1'b0;
                        col_last_r   <= 1'b0;
                    end else if (col_acc_s) begin
                        col_cnt_r    <= col_cnt_r + CNT_W'(1);
                        line_ready_r <= 1'b0;
                        col_valid_r  <= 1'b1;
                        col_last_r   <= ((col_cnt_r + CNT_W'(1)) == LAST_IDX);
                    end else begin
                        // Backpressure: hold the presented column.
                        line_ready_r <= 1'b0;
                        col_valid_r  <= 1'b1;
                        col_last_r   <= col_last_r;
                    end
                end
                default: begin
                    state_r      <= ST_FILL;
                    row_cnt_r    <= {CNT_W{1'b0}};
                    col_cnt_r    <= {CNT_W{1'b0}};
                    line_ready_r <= 1'b0;
                    col_valid_r  <= 1'b0;
                    col_last_r   <= 1'b0;
                end
            endcase
        end
    end

    // Column output is gated to zero whenever no column is being presented.
    always_comb begin
        col_out_s = {LINE_W{1'b0}};
        if (col_valid_r) begin
            col_out_s = col_data_s;
        end else begin
            col_out_s = {LINE_W{1'b0}};
        end
    end

    assign LINE_READY = line_ready_r;
    assign COL_VALID  = col_valid_r;
    assign COL_LAST   = col_last_r;
    assign COL_OUT    = col_out_s;
    // BUSY includes the line being accepted this cycle, so it rises together
    // with the first accept rather than one cycle later.
    assign BUSY       = (state_r == ST_DRAIN) | (row_cnt_r != {CNT_W{1'b0}}) | line_acc_s;

endmodule

// File: tb/tb_interp_col_transpose_buffer.sv
// -----------------------------------------------------------------------------
// tb_interp_col_transpose_buffer
// Directed bench for the column transpose buffer. Inputs are driven and
// outputs sampled on the falling edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_interp_col_transpose_buffer;

    localparam int SW = 9;
    localparam int NS = 11;
    localparam int LW = 99;

    logic          CLK;
    logic          RST;
    logic [LW-1:0] LINE_IN;
    logic          LINE_VALID;
    logic          LINE_READY;
    logic [LW-1:0] COL_OUT;
    logic          COL_VALID;
    logic          COL_READY;
    logic          COL_LAST;
    logic          BUSY;

    int checks;
    int failures;

    // Results gathered by the drain helper, judged by each test.
    logic [LW-1:0] got_cols [NS];
    int            got_n;
    int            last_err;
    int            stable_err;
    int            lr_err;
    bit            drain_tmo;

    interp_col_transpose_buffer dut (
        .CLK        (CLK),
        .RST        (RST),
        .LINE_IN    (LINE_IN),
        .LINE_VALID (LINE_VALID),
        .LINE_READY (LINE_READY),
        .COL_OUT    (COL_OUT),
        .COL_VALID  (COL_VALID),
        .COL_READY  (COL_READY),
        .COL_LAST   (COL_LAST),
        .BUSY       (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference sample (row r, column c) for each data pattern.
    function automatic logic [SW-1:0] exp_sample(input int kind, input int r, input int c);
        case (kind)
            0:       return SW'(11 * r + c);
            1:       return 9'h1FF;
            2:       return 9'h000;
            3:       return ((r == 0) && (c == 10)) ? 9'h155 : 9'h000;
            4:       return SW'(511 - (11 * r + c));
            default: return 9'h000;
        endcase
    endfunction

    function automatic logic [LW-1:0] make_line(input int kind, input int r);
        logic [LW-1:0] l;
        l = '0;
        for (int c = 0; c < NS; c++) l[SW*c +: SW] = exp_sample(kind, r, c);
        return l;
    endfunction

    function automatic logic [LW-1:0] exp_col(input int kind, input int k);
        logic [LW-1:0] l;
        l = '0;
        for (int r = 0; r < NS; r++) l[SW*r +: SW] = exp_sample(kind, r, k);
        return l;
    endfunction

    // Feed nlines lines, LINE_VALID asserted every 'gap' cycles.
    task automatic feed_block(input int kind, input int gap, input int nlines,
                              output int cycles, output bit busy_pre,
                              output bit busy_first, output bit tmo);
        int r;
        bit acc;
        r = 0; cycles = 0; tmo = 1'b0; busy_pre = 1'b0; busy_first = 1'b0;
        while (r < nlines) begin
            if (cycles >= 400) begin
                tmo = 1'b1;
                break;
            end
            if (r == 0) busy_pre = BUSY;
            LINE_IN    = make_line(kind, r);
            LINE_VALID = ((cycles % gap) == 0);
            #1;
            acc = LINE_VALID & LINE_READY;
            if (acc && (r == 0)) busy_first = BUSY;
            @(negedge CLK);
            cycles++;
            if (acc) r++;
        end
        LINE_VALID = 1'b0;
        LINE_IN    = '0;
    endtask

    // Take ncols columns; bp selects the 1,0,0 ready pattern.
    task automatic drain_block(input int ncols, input bit bp);
        int cyc;
        bit prev_hold;
        logic [LW-1:0] prev_out;
        got_n = 0; cyc = 0; last_err = 0; stable_err = 0; lr_err = 0;
        drain_tmo = 1'b0; prev_hold = 1'b0; prev_out = '0;
        for (int k = 0; k < NS; k++) got_cols[k] = '0;
        while (got_n < ncols) begin
            if (cyc >= 400) begin
                drain_tmo = 1'b1;
                break;
            end
            COL_READY = bp ? ((cyc % 3) == 0) : 1'b1;
            if (COL_VALID) begin
                if (prev_hold && (COL_OUT !== prev_out)) stable_err++;
                if (LINE_READY) lr_err++;
                if (COL_LAST !== (got_n == NS - 1)) last_err++;
                if (COL_READY) begin
                    got_cols[got_n] = COL_OUT;
                    got_n++;
                end
                prev_hold = !COL_READY;
                prev_out  = COL_OUT;
            end else begin
                if (prev_hold) stable_err++;
                prev_hold = 1'b0;
            end
            @(negedge CLK);
            cyc++;
        end
        COL_READY = 1'b0;
    endtask

    task automatic pulse_reset();
        RST = 1'b1; LINE_VALID = 1'b0; COL_READY = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1'b1; LINE_VALID = 1'b0; COL_READY = 1'b0; LINE_IN = '0;
        @(negedge CLK);
        @(negedge CLK);
        checks++; if (LINE_READY !== 1'b0) begin failures++; $display("FAIL reset_line_ready: got %b expected 0", LINE_READY); end
        checks++; if (COL_VALID !== 1'b0) begin failures++; $display("FAIL reset_col_valid: got %b expected 0", COL_VALID); end
        checks++; if (COL_LAST !== 1'b0) begin failures++; $display("FAIL reset_col_last: got %b expected 0", COL_LAST); end
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
        checks++; if (COL_OUT !== '0) begin failures++; $display("FAIL reset_col_out: got %h expected 0", COL_OUT); end
        RST = 1'b0;
        @(negedge CLK);
        checks++; if (LINE_READY !== 1'b1) begin failures++; $display("FAIL post_reset_line_ready: got %b expected 1", LINE_READY); end
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL post_reset_busy: got %b expected 0", BUSY); end
    endtask

    task automatic test_basic();
        int cyc; bit bp0, bf, tmo;
        feed_block(0, 1, NS, cyc, bp0, bf, tmo);
        checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL basic_feed_timeout: got %b expected 0", tmo); end
        checks++; if (cyc !== NS) begin failures++; $display("FAIL basic_feed_cycles: got %0d expected %0d", cyc, NS); end
        checks++; if (COL_VALID !== 1'b1) begin failures++; $display("FAIL basic_first_col_latency: got %b expected 1", COL_VALID); end
        checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL basic_busy_drain: got %b expected 1", BUSY); end
        drain_block(NS, 1'b0);
        checks++; if (drain_tmo !== 1'b0) begin failures++; $display("FAIL basic_drain_timeout: got %b expected 0", drain_tmo); end
        for (int k = 0; k < NS; k++) begin
            checks++;
            if (got_cols[k] !== exp_col(0, k)) begin
                failures++; $display("FAIL basic_col%0d: got %h expected %h", k, got_cols[k], exp_col(0, k));
            end
        end
        checks++; if (last_err !== 0) begin failures++; $display("FAIL basic_col_last: got %0d bad cycles expected 0", last_err); end
        checks++; if (lr_err !== 0) begin failures++; $display("FAIL basic_line_ready_in_drain: got %0d expected 0", lr_err); end
        checks++; if (COL_VALID !== 1'b0) begin failures++; $display("FAIL basic_bubble_col_valid: got %b expected 0", COL_VALID); end
        checks++; if (LINE_READY !== 1'b1) begin failures++; $display("FAIL basic_bubble_line_ready: got %b expected 1", LINE_READY); end
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL basic_idle_busy: got %b expected 0", BUSY); end
        checks++; if (COL_OUT !== '0) begin failures++; $display("FAIL basic_idle_col_out: got %h expected 0", COL_OUT); end
    endtask

    task automatic test_backpressure();
        int cyc; bit bp0, bf, tmo;
        feed_block(0, 1, NS, cyc, bp0, bf, tmo);
        drain_block(NS, 1'b1);
        checks++; if (drain_tmo !== 1'b0) begin failures++; $display("FAIL bp_drain_timeout: got %b expected 0", drain_tmo); end
        for (int k = 0; k < NS; k++) begin
            checks++;
            if (got_cols[k] !== exp_col(0, k)) begin
                failures++; $display("FAIL bp_col%0d: got %h expected %h", k, got_cols[k], exp_col(0, k));
            end
        end
        checks++; if (stable_err !== 0) begin failures++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", stable_err); end
        checks++; if (lr_err !== 0) begin failures++; $display("FAIL bp_line_ready: got %0d expected 0", lr_err); end
        checks++; if (last_err !== 0) begin failures++; $display("FAIL bp_col_last: got %0d expected 0", last_err); end
        checks++; if (LINE_READY !== 1'b1) begin failures++; $display("FAIL bp_after_line_ready: got %b expected 1", LINE_READY); end
    endtask

    task automatic test_gapped();
        int cyc; bit bp0, bf, tmo;
        feed_block(0, 3, NS, cyc, bp0, bf, tmo);
        checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL gap_feed_timeout: got %b expected 0", tmo); end
        checks++; if (bp0 !== 1'b0) begin failures++; $display("FAIL gap_busy_before: got %b expected 0", bp0); end
        checks++; if (bf !== 1'b1) begin failures++; $display("FAIL gap_busy_first_accept: got %b expected 1", bf); end
        checks++; if (cyc !== 3 * (NS - 1) + 1) begin failures++; $display("FAIL gap_feed_cycles: got %0d expected %0d", cyc, 3 * (NS - 1) + 1); end
        checks++; if (COL_VALID !== 1'b1) begin failures++; $display("FAIL gap_first_col_latency: got %b expected 1", COL_VALID); end
        drain_block(NS, 1'b0);
        for (int k = 0; k < NS; k++) begin
            checks++;
            if (got_cols[k] !== exp_col(0, k)) begin
                failures++; $display("FAIL gap_col%0d: got %h expected %h", k, got_cols[k], exp_col(0, k));
            end
        end
        checks++; if (COL_VALID !== 1'b0) begin failures++; $display("FAIL gap_no_extra_col: got %b expected 0", COL_VALID); end
    endtask

    task automatic test_back_to_back();
        int cyc; bit bp0, bf, tmo;
        feed_block(1, 1, NS, cyc, bp0, bf, tmo);
        drain_block(NS, 1'b0);
        for (int k = 0; k < NS; k++) begin
            checks++;
            if (got_cols[k] !== exp_col(1, k)) begin
                failures++; $display("FAIL b2b_a_col%0d: got %h expected %h", k, got_cols[k], exp_col(1, k));
            end
        end
        checks++; if (LINE_READY !== 1'b1) begin failures++; $display("FAIL b2b_bubble_line_ready: got %b expected 1", LINE_READY); end
        checks++; if (COL_VALID !== 1'b0) begin failures++; $display("FAIL b2b_bubble_col_valid: got %b expected 0", COL_VALID); end
        feed_block(2, 1, NS, cyc, bp0, bf, tmo);
        checks++; if (cyc !== NS) begin failures++; $display("FAIL b2b_b_fill_cycles: got %0d expected %0d", cyc, NS); end
        drain_block(NS, 1'b0);
        for (int k = 0; k < NS; k++) begin
            checks++;
            if (got_cols[k] !== exp_col(2, k)) begin
                failures++; $display("FAIL b2b_b_col%0d: got %h expected %h", k, got_cols[k], exp_col(2, k));
            end
        end
        checks++; if (last_err !== 0) begin failures++; $display("FAIL b2b_b_col_last: got %0d expected 0", last_err); end
    endtask

    task automatic test_reset_mid();
        int cyc; bit bp0, bf, tmo;
        // Abort during fill.
        feed_block(1, 1, 5, cyc, bp0, bf, tmo);
        checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL rmid_fill_busy: got %b expected 1", BUSY); end
        pulse_reset();
        checks++; if (COL_VALID !== 1'b0) begin failures++; $display("FAIL rmid_fill_col_valid: got %b expected 0", COL_VALID); end
        checks++; if (LINE_READY !== 1'b1) begin failures++; $display("FAIL rmid_fill_line_ready: got %b expected 1", LINE_READY); end
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL rmid_fill_busy_after: got %b expected 0", BUSY); end
        feed_block(0, 1, NS, cyc, bp0, bf, tmo);
        checks++; if (cyc !== NS) begin failures++; $display("FAIL rmid_fill_refill_cycles: got %0d expected %0d", cyc, NS); end
        drain_block(NS, 1'b0);
        for (int k = 0; k < NS; k++) begin
            checks++;
            if (got_cols[k] !== exp_col(0, k)) begin
                failures++; $display("FAIL rmid_fill_col%0d: got %h expected %h", k, got_cols[k], exp_col(0, k));
            end
        end
        // Abort during drain, after four columns.
        feed_block(1, 1, NS, cyc, bp0, bf, tmo);
        drain_block(4, 1'b0);
        checks++; if (COL_VALID !== 1'b1) begin failures++; $display("FAIL rmid_drain_mid_valid: got %b expected 1", COL_VALID); end
        pulse_reset();
        checks++; if (COL_VALID !== 1'b0) begin failures++; $display("FAIL rmid_drain_col_valid: got %b expected 0", COL_VALID); end
        checks++; if (LINE_READY !== 1'b1) begin failures++; $display("FAIL rmid_drain_line_ready: got %b expected 1", LINE_READY); end
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL rmid_drain_busy: got %b expected 0", BUSY); end
        checks++; if (COL_OUT !== '0) begin failures++; $display("FAIL rmid_drain_col_out: got %h expected 0", COL_OUT); end
        feed_block(4, 1, NS, cyc, bp0, bf, tmo);
        drain_block(NS, 1'b0);
        for (int k = 0; k < NS; k++) begin
            checks++;
            if (got_cols[k] !== exp_col(4, k)) begin
                failures++; $display("FAIL rmid_drain_col%0d: got %h expected %h", k, got_cols[k], exp_col(4, k));
            end
        end
    endtask

    task automatic test_boundary();
        int cyc; bit bp0, bf, tmo;
        logic [LW-1:0] c10;
        feed_block(3, 1, NS, cyc, bp0, bf, tmo);
        drain_block(NS, 1'b0);
        c10 = got_cols[NS - 1];
        checks++; if (c10[8:0] !== 9'h155) begin failures++; $display("FAIL bound_col10_slot0: got %h expected 155", c10[8:0]); end
        for (int k = 0; k < NS; k++) begin
            checks++;
            if (got_cols[k] !== exp_col(3, k)) begin
                failures++; $display("FAIL bound_col%0d: got %h expected %h", k, got_cols[k], exp_col(3, k));
            end
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        RST = 1'b1; LINE_VALID = 1'b0; COL_READY = 1'b0; LINE_IN = '0;
        @(negedge CLK);
        test_reset();
        test_basic();
        test_backpressure();
        test_gapped();
        test_back_to_back();
        test_reset_mid();
        test_boundary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
